mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT, default 16, number of consecutive un-acknowledged request cycles before a data access is aborted.
REQ-002 clk  in  1  clock, all state updates on rising edge.
REQ-003 reset_n  in  1  reset, synchronous, active-low.
REQ-004 ALU_out_MEM  in  32  EX result; data address for load/store, result for ALU ops.
REQ-005 S2_MEM  in  32  store data (forwarded Rs2 value registered by EX).
REQ-006 d_write_enable_MEM / d_load_enable_MEM  in  1 each  store / load in MEM; never both set.
REQ-007 Rd_MEM  in  5  destination register.
REQ-008 d_req, d_we  out  1 each  data-bus request; write qualifier.
REQ-009 d_addr, d_wdata  out  32 each  bus address, store data.
REQ-010 d_ack  in  1 / d_rdata  in  32  bus completion, load data (valid with d_ack).
REQ-011 stall_MEM  out  1  freezes all upstream pipeline registers and PC.
REQ-012 ALU_out_MEM_backward  out  32 / Rd_MEM_backward  out  5  forwarding path to EX.
REQ-013 Res_WB  out  32 / Rd_WB  out  5 / reg_we_WB  out  1  registered writeback bundle.
REQ-014 mem_err  out  1  one-cycle pulse on access timeout.

Function
REQ-015 FSM states IDLE, WAIT, ABORT; mem_op = d_load_enable_MEM | d_write_enable_MEM.
REQ-016 d_req = mem_op in IDLE or WAIT, 0 in ABORT; d_we = d_write_enable_MEM; d_addr = ALU_out_MEM; d_wdata = S2_MEM (all combinational).
REQ-017 Zero-wait: d_ack in the same cycle as d_req completes the access; no stall, FSM stays IDLE.
REQ-018 stall_MEM = d_req & ~d_ack; IDLE -> WAIT on d_req & ~d_ack; WAIT -> IDLE on d_ack.
REQ-019 Wait counter clears on entering WAIT, increments each WAIT cycle without d_ack; WAIT -> ABORT when count reaches TIMEOUT-1 without d_ack.
REQ-020 ABORT lasts exactly one cycle: stall_MEM=0, mem_err=1, no writeback; ABORT -> IDLE.
REQ-021 d_ack while d_req=0 is ignored.
REQ-022 Writeback register loads on every non-stalled cycle: Res_WB = d_rdata for load, else ALU_out_MEM; Rd_WB = Rd_MEM; reg_we_WB = ~d_write_enable_MEM & (Rd_MEM != 0) & (state != ABORT).
REQ-023 Stalled cycle inserts a bubble: reg_we_WB=0, Rd_WB=0, Res_WB held.
REQ-024 ALU_out_MEM_backward = ALU_out_MEM; Rd_MEM_backward = Rd_MEM, forced to 0 when d_load_enable_MEM (load data not yet forwardable).
REQ-025 Latency: writeback bundle valid one cycle after access completion; ALU ops one cycle after entry.

Reset
REQ-026 reset_n=0 at a rising edge: state IDLE, counter 0, Res_WB=0, Rd_WB=0, reg_we_WB=0, mem_err=0.
REQ-027 Reset mid-WAIT abandons the access with no writeback; d_req follows inputs combinationally, so it remains asserted only if EX still presents a mem op after reset.

Structure
REQ-028 Shared package dlx_pkg holds the mem FSM state enum, REG_IDX_W=5, R0 constant and default TIMEOUT.
REQ-029 Sub-module mem_timeout_counter (clear, enable, expired) implements the wait counter; the FSM stays in mem_stage.

Verification
REQ-030 ALU op, ALU_out=0x00000010, Rd=3 -> next cycle Res_WB=0x10, Rd_WB=3, reg_we_WB=1, stall_MEM never set.
REQ-031 Load addr 0x100, d_ack after 3 cycles with d_rdata=0xCAFEF00D -> stall_MEM=1 for 3 cycles, bubbles written, then Res_WB=0xCAFEF00D, reg_we_WB=1.
REQ-032 Store addr 0x200, data 0x12345678, zero-wait ack -> d_we=1, d_wdata=0x12345678, no stall, reg_we_WB=0.
REQ-033 Load, d_ack never asserted, TIMEOUT=16 -> stall_MEM=1 for 16 cycles, then one ABORT cycle with mem_err=1, reg_we_WB=0, FSM back to IDLE.
REQ-034 ALU op with Rd=0 -> reg_we_WB=0; load with Rd=5 -> Rd_MEM_backward=0.
REQ-035 reset_n=0 during WAIT cycle 2 -> next edge all outputs at REQ-026 values, no write of load result.

Source files
------------

// File: rtl/dlx_pkg.sv
// rtl/dlx_pkg.sv - shared DLX definitions: memory FSM states, register index width, defaults
//
// Purpose : types and constants shared by the MEM stage and its helpers.
// Contents: mem_state_e   - MEM access FSM states (IDLE, WAIT, ABORT)
//           REG_IDX_W     - register index width
//           R0            - index of the hard-wired zero register
//           DEFAULT_TIMEOUT - default un-acknowledged request cycles before abort
package dlx_pkg;

  localparam int REG_IDX_W       = 5;
  localparam int DEFAULT_TIMEOUT = 16;

  localparam logic [REG_IDX_W-1:0] R0 = '0;

  typedef enum logic [1:0] {
    MEM_IDLE  = 2'd0,
    MEM_WAIT  = 2'd1,
    MEM_ABORT = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_timeout_counter.sv
// rtl/mem_timeout_counter.sv - wait-cycle counter for the MEM stage data access
//
// Purpose : counts WAIT cycles without acknowledge and flags the cycle in
//           which the count reaches TIMEOUT-1.
// Ports   : clk, reset_n - clock, synchronous active-low reset
//           clear_i      - restart count at 0 (entering WAIT)
//           enable_i     - WAIT cycle without acknowledge, count up
//           expired_o    - this enabled cycle brings the count to TIMEOUT-1
module mem_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  // The request cycle in IDLE already counts as one stalled cycle, so the
  // last WAIT cycle is the one holding TIMEOUT-2; its increment reaches TIMEOUT-1.
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 2);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = enable_i & (cnt_q == LAST);

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - DLX MEM pipeline stage with data-bus handshake, timeout and writeback register
//
// Purpose : issues load/store accesses on the data bus, stalls the pipeline
//           while an access is outstanding, aborts after TIMEOUT stalled
//           cycles, and registers the writeback bundle.
// Ports   : clk, reset_n                      - clock, synchronous active-low reset
//           ALU_out_MEM, S2_MEM, Rd_MEM       - EX result/address, store data, destination
//           d_write_enable_MEM, d_load_enable_MEM - store / load in MEM
//           d_req, d_we, d_addr, d_wdata      - data-bus request side
//           d_ack, d_rdata                    - data-bus completion side
//           stall_MEM                         - freeze upstream stages and PC
//           ALU_out_MEM_backward, Rd_MEM_backward - forwarding path to EX
//           Res_WB, Rd_WB, reg_we_WB          - registered writeback bundle
//           mem_err                           - one-cycle pulse on access timeout
module mem_stage
  import dlx_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [31:0]          ALU_out_MEM,
  input  logic [31:0]          S2_MEM,
  input  logic                 d_write_enable_MEM,
  input  logic                 d_load_enable_MEM,
  input  logic [REG_IDX_W-1:0] Rd_MEM,
  output logic                 d_req,
  output logic                 d_we,
  output logic [31:0]          d_addr,
  output logic [31:0]          d_wdata,
  input  logic                 d_ack,
  input  logic [31:0]          d_rdata,
  output logic                 stall_MEM,
  output logic [31:0]          ALU_out_MEM_backward,
  output logic [REG_IDX_W-1:0] Rd_MEM_backward,
  output logic [31:0]          Res_WB,
  output logic [REG_IDX_W-1:0] Rd_WB,
  output logic                 reg_we_WB,
  output logic                 mem_err
);

  mem_state_e state_q, state_d;
  logic       mem_op;
  logic       cnt_clr, cnt_en, cnt_expired;

  logic [31:0]          res_q, res_d;
  logic [REG_IDX_W-1:0] rd_q, rd_d;
  logic                 we_q, we_d;

  assign mem_op    = d_load_enable_MEM | d_write_enable_MEM;
  assign d_req     = mem_op & (state_q != MEM_ABORT);
  assign d_we      = d_write_enable_MEM;
  assign d_addr    = ALU_out_MEM;
  assign d_wdata   = S2_MEM;
  assign stall_MEM = d_req & ~d_ack;
  assign mem_err   = (state_q == MEM_ABORT);

  assign ALU_out_MEM_backward = ALU_out_MEM;
  // Load data only exists after the bus answers, so a load must not be
  // offered to EX as a forwarding source.
  assign Rd_MEM_backward      = d_load_enable_MEM ? R0 : Rd_MEM;

  mem_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear_i   (cnt_clr),
    .enable_i  (cnt_en),
    .expired_o (cnt_expired)
  );

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      MEM_IDLE: begin
        if (stall_MEM) begin
          state_d = MEM_WAIT;
          cnt_clr = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!d_req || d_ack) begin
          state_d = MEM_IDLE;
        end else begin
          cnt_en = 1'b1;
          if (cnt_expired) begin
            state_d = MEM_ABORT;
          end
        end
      end
      MEM_ABORT: state_d = MEM_IDLE;
      default:   state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= MEM_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Stalled cycles push a bubble into WB while keeping the last result.
  always_comb begin
    res_d = res_q;
    rd_d  = R0;
    we_d  = 1'b0;
    if (!stall_MEM) begin
      res_d = d_load_enable_MEM ? d_rdata : ALU_out_MEM;
      rd_d  = Rd_MEM;
      we_d  = ~d_write_enable_MEM & (Rd_MEM != R0) & (state_q != MEM_ABORT);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      res_q <= '0;
      rd_q  <= R0;
      we_q  <= 1'b0;
    end else begin
      res_q <= res_d;
      rd_q  <= rd_d;
      we_q  <= we_d;
    end
  end

  assign Res_WB    = res_q;
  assign Rd_WB     = rd_q;
  assign reg_we_WB = we_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage against a transaction-level model
module tb_mem_stage;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] ALU_out_MEM = '0, S2_MEM = '0, d_rdata = '0;
  logic        d_write_enable_MEM = 1'b0, d_load_enable_MEM = 1'b0, d_ack = 1'b0;
  logic [4:0]  Rd_MEM = '0;
  logic        d_req, d_we, stall_MEM, reg_we_WB, mem_err;
  logic [31:0] d_addr, d_wdata, ALU_out_MEM_backward, Res_WB;
  logic [4:0]  Rd_MEM_backward, Rd_WB;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_res = '0;
  bit          res_known = 1'b1;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .ALU_out_MEM          (ALU_out_MEM),
    .S2_MEM               (S2_MEM),
    .d_write_enable_MEM   (d_write_enable_MEM),
    .d_load_enable_MEM    (d_load_enable_MEM),
    .Rd_MEM               (Rd_MEM),
    .d_req                (d_req),
    .d_we                 (d_we),
    .d_addr               (d_addr),
    .d_wdata              (d_wdata),
    .d_ack                (d_ack),
    .d_rdata              (d_rdata),
    .stall_MEM            (stall_MEM),
    .ALU_out_MEM_backward (ALU_out_MEM_backward),
    .Rd_MEM_backward      (Rd_MEM_backward),
    .Res_WB               (Res_WB),
    .Rd_WB                (Rd_WB),
    .reg_we_WB            (reg_we_WB),
    .mem_err              (mem_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One instruction in MEM. op: 0 ALU, 1 load, 2 store. lat: cycles until
  // d_ack (0 = same cycle); lat >= TIMEOUT means the bus never answers.
  task automatic run_instr(input int op, input logic [31:0] alu, input logic [31:0] wd,
                           input logic [31:0] rdat, input logic [4:0] rd, input int lat);
    bit ld, st, memop, abort, stall_e, ab_cyc;
    int ncyc;
    ld    = (op == 1);
    st    = (op == 2);
    memop = (op != 0);
    abort = memop && (lat >= TIMEOUT);
    ncyc  = !memop ? 1 : (abort ? TIMEOUT + 1 : lat + 1);
    for (int c = 0; c < ncyc; c++) begin
      ab_cyc  = abort && (c == TIMEOUT);
      stall_e = memop && !ab_cyc && (c < lat);
      ALU_out_MEM        = alu;
      S2_MEM             = wd;
      d_load_enable_MEM  = ld;
      d_write_enable_MEM = st;
      Rd_MEM             = rd;
      if (memop && !ab_cyc) d_ack = !abort && (c == lat);
      else                  d_ack = 1'($urandom_range(0, 1));
      d_rdata = ld ? rdat : $urandom;
      #1;
      chk("stall_MEM", stall_MEM, stall_e);
      chk("d_req", d_req, memop && !ab_cyc);
      chk("mem_err", mem_err, ab_cyc);
      chk("fwd_alu", ALU_out_MEM_backward, alu);
      chk("fwd_rd", Rd_MEM_backward, ld ? 5'd0 : rd);
      if (memop && !ab_cyc) begin
        chk("d_we", d_we, st);
        chk("d_addr", d_addr, alu);
        chk("d_wdata", d_wdata, wd);
      end
      @(posedge clk);
      #1;
      if (stall_e) begin
        chk("bubble_we", reg_we_WB, 1'b0);
        chk("bubble_rd", Rd_WB, 5'd0);
        if (res_known) chk("bubble_res_held", Res_WB, exp_res);
      end else if (ab_cyc) begin
        chk("abort_we", reg_we_WB, 1'b0);
        res_known = 1'b0;
      end else begin
        exp_res   = ld ? rdat : alu;
        res_known = 1'b1;
        chk("wb_res", Res_WB, exp_res);
        chk("wb_rd", Rd_WB, rd);
        chk("wb_we", reg_we_WB, !st && (rd != 5'd0));
      end
    end
  endtask

  task automatic go_idle();
    d_load_enable_MEM  = 1'b0;
    d_write_enable_MEM = 1'b0;
    d_ack              = 1'b0;
  endtask

  initial begin
    int op, lat, sel;
    reset_n = 1'b0;
    go_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res", Res_WB, 32'd0);
    chk("rst_rd", Rd_WB, 5'd0);
    chk("rst_we", reg_we_WB, 1'b0);
    chk("rst_err", mem_err, 1'b0);
    chk("rst_stall", stall_MEM, 1'b0);
    reset_n = 1'b1;

    // Directed cases
    run_instr(0, 32'h0000_0010, 32'h0, 32'h0, 5'd3, 0);
    run_instr(1, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 5'd7, 3);
    run_instr(2, 32'h0000_0200, 32'h1234_5678, 32'h0, 5'd9, 0);
    run_instr(1, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 5'd4, TIMEOUT);
    run_instr(0, 32'h0000_0055, 32'h0, 32'h0, 5'd0, 0);
    run_instr(1, 32'h0000_0108, 32'h0, 32'h0BAD_F00D, 5'd5, 0);
    run_instr(1, 32'h0000_010C, 32'h0, 32'h1111_2222, 5'd6, TIMEOUT - 1);

    // Reset during the second WAIT cycle of a load
    ALU_out_MEM = 32'h300; d_load_enable_MEM = 1'b1; d_write_enable_MEM = 1'b0;
    Rd_MEM = 5'd8; d_ack = 1'b0; d_rdata = 32'h5555_AAAA;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("midrst_res", Res_WB, 32'd0);
    chk("midrst_rd", Rd_WB, 5'd0);
    chk("midrst_we", reg_we_WB, 1'b0);
    chk("midrst_err", mem_err, 1'b0);
    go_idle();
    #1;
    chk("midrst_stall", stall_MEM, 1'b0);
    chk("midrst_req", d_req, 1'b0);
    exp_res   = '0;
    res_known = 1'b1;

    // Randomized instruction stream
    for (int i = 0; i < 60; i++) begin
      op  = int'($urandom_range(0, 2));
      sel = int'($urandom_range(0, 9));
      if (sel < 7)       lat = int'($urandom_range(0, 4));
      else if (sel == 7) lat = TIMEOUT - 1;
      else if (sel == 8) lat = TIMEOUT;
      else               lat = TIMEOUT + 1;
      run_instr(op, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)), lat);
    end

    go_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
